// File: rtl/cam_link_pkg.sv
// Shared constants and state encodings for the PC-to-FPGA camera debug link.
// Packet framing is [SYNC_BYTE, CMD, ARG0, ARG1, CHK] with CHK = CMD ^ ARG0 ^ ARG1.
package cam_link_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam logic [7:0] CMD_CAPTURE = 8'h01;
    localparam logic [7:0] CMD_REGWR   = 8'h02;
    localparam logic [7:0] CMD_RESEND  = 8'h03;

    // Bit-level receiver states
    typedef logic [2:0] rx_state_t;
    localparam rx_state_t R_IDLE  = 3'd0;
    localparam rx_state_t R_START = 3'd1;
    localparam rx_state_t R_DATA  = 3'd2;
    localparam rx_state_t R_STOP  = 3'd3;
    localparam rx_state_t R_BREAK = 3'd4;

    // Packet parser states
    typedef logic [2:0] pkt_state_t;
    localparam pkt_state_t P_SYNC = 3'd0;
    localparam pkt_state_t P_CMD  = 3'd1;
    localparam pkt_state_t P_ARG0 = 3'd2;
    localparam pkt_state_t P_ARG1 = 3'd3;
    localparam pkt_state_t P_CHK  = 3'd4;
    localparam pkt_state_t P_HOLD = 3'd5;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } cfg_req_t;

    function automatic logic [7:0] pkt_chk(input logic [7:0] c, input logic [7:0] a0,
                                           input logic [7:0] a1);
        return c ^ a0 ^ a1;
    endfunction

endpackage

// File: rtl/uart_cmd_rx_if.sv
// Output bundle of the command receiver: byte tap, strobes, register-write handshake, errors.
// master = receiver side (drives everything except cfg_ready), slave = consumer side.
interface uart_cmd_rx_if;

    logic       rx_byte_valid;
    logic [7:0] rx_byte;
    logic       capture_pulse;
    logic       resend_pulse;
    logic       cfg_valid;
    logic [7:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       cfg_ready;
    logic       err_frame;
    logic       err_chk;
    logic       err_cmd;
    logic       err_ovr;
    logic       err_timeout;

    modport master (
        output rx_byte_valid, rx_byte, capture_pulse, resend_pulse,
        output cfg_valid, cfg_addr, cfg_data,
        output err_frame, err_chk, err_cmd, err_ovr, err_timeout,
        input  cfg_ready
    );

    modport slave (
        input  rx_byte_valid, rx_byte, capture_pulse, resend_pulse,
        input  cfg_valid, cfg_addr, cfg_data,
        input  err_frame, err_chk, err_cmd, err_ovr, err_timeout,
        output cfg_ready
    );

endinterface

// File: rtl/uart_rx.sv
// 8N1 UART deserialiser: 2-FF synchroniser, mid-bit sampling, framing check.
// A low stop bit drops the byte and parks in R_BREAK until the line returns high.
module uart_rx
    import cam_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       rx_serial_i,
    output logic [7:0] rx_byte_o,
    output logic       rx_byte_valid_o,
    output logic       err_frame_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             sync1_q, sync2_q;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       byte_q, byte_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            R_IDLE: begin
                cnt_d = '0;
                if (!sync2_q) state_d = R_START;
            end
            R_START: begin
                // Re-check at mid start bit so short glitches are rejected
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = sync2_q ? R_IDLE : R_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            R_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    shreg_d = {sync2_q, shreg_q[7:1]};
                    if (bit_q == 3'd7) state_d = R_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            R_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
                    if (sync2_q) begin
                        byte_d  = shreg_q;
                        valid_d = 1'b1;
                        state_d = R_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = R_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            R_BREAK: begin
                if (sync2_q) state_d = R_IDLE;
            end
            default: state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= R_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shreg_q <= 8'h00;
            byte_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rx_serial_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_byte_o       = byte_q;
    assign rx_byte_valid_o = valid_q;
    assign err_frame_o     = ferr_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// Host command receiver: UART byte stream -> framed packet parser -> strobes / register writes.
// Optional CMD_TIMEOUT_EN aborts a partial packet after TIMEOUT_CLKS idle clocks.
module uart_cmd_rx
    import cam_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10416,
    parameter int TIMEOUT_CLKS = 2000000
) (
    input  logic          clk,
    input  logic          reset_p,
    input  logic          rx_serial,
    uart_cmd_rx_if.master cmd
);

    logic [7:0] rx_byte;
    logic       byte_vld;
    logic       ferr;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk            (clk),
        .reset_p        (reset_p),
        .rx_serial_i    (rx_serial),
        .rx_byte_o      (rx_byte),
        .rx_byte_valid_o(byte_vld),
        .err_frame_o    (ferr)
    );

    pkt_state_t pst_q, pst_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] arg0_q, arg0_d;
    logic [7:0] arg1_q, arg1_d;
    cfg_req_t   cfg_q, cfg_d;
    logic       cfg_valid_q, cfg_valid_d;
    logic       cap_q, cap_d;
    logic       res_q, res_d;
    logic       echk_q, echk_d;
    logic       ecmd_q, ecmd_d;
    logic       eovr_q, eovr_d;
    logic       eto_q, eto_d;
    logic       to_fire;

`ifdef CMD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
    logic [TO_W-1:0] to_cnt_q;
    logic            in_pkt;

    assign in_pkt  = (pst_q == P_CMD) || (pst_q == P_ARG0) || (pst_q == P_ARG1) || (pst_q == P_CHK);
    assign to_fire = in_pkt && !byte_vld && (to_cnt_q == TO_W'(TIMEOUT_CLKS - 1));

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p)                 to_cnt_q <= '0;
        else if (byte_vld || !in_pkt) to_cnt_q <= '0;
        else                          to_cnt_q <= to_cnt_q + 1'b1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CLKS != 0);
    assign to_fire        = 1'b0;
`endif

    always_comb begin
        pst_d       = pst_q;
        cmd_d       = cmd_q;
        arg0_d      = arg0_q;
        arg1_d      = arg1_q;
        cfg_d       = cfg_q;
        cfg_valid_d = cfg_valid_q;
        cap_d       = 1'b0;
        res_d       = 1'b0;
        echk_d      = 1'b0;
        ecmd_d      = 1'b0;
        eovr_d      = 1'b0;
        eto_d       = 1'b0;
        case (pst_q)
            P_SYNC: if (byte_vld && rx_byte == SYNC_BYTE) pst_d = P_CMD;
            P_CMD: if (byte_vld) begin
                cmd_d = rx_byte;
                pst_d = P_ARG0;
            end
            P_ARG0: if (byte_vld) begin
                arg0_d = rx_byte;
                pst_d  = P_ARG1;
            end
            P_ARG1: if (byte_vld) begin
                arg1_d = rx_byte;
                pst_d  = P_CHK;
            end
            P_CHK: if (byte_vld) begin
                pst_d = P_SYNC;
                if (rx_byte != pkt_chk(cmd_q, arg0_q, arg1_q)) begin
                    echk_d = 1'b1;
                end else begin
                    case (cmd_q)
                        CMD_CAPTURE: cap_d = 1'b1;
                        CMD_RESEND:  res_d = 1'b1;
                        CMD_REGWR: begin
                            cfg_d       = '{addr: arg0_q, data: arg1_q};
                            cfg_valid_d = 1'b1;
                            pst_d       = P_HOLD;
                        end
                        default:     ecmd_d = 1'b1;
                    endcase
                end
            end
            P_HOLD: begin
                // Bytes are not buffered while a write is outstanding
                if (byte_vld) eovr_d = 1'b1;
                if (cfg_valid_q && cmd.cfg_ready) begin
                    cfg_valid_d = 1'b0;
                    pst_d       = P_SYNC;
                end
            end
            default: pst_d = P_SYNC;
        endcase
        if (to_fire) begin
            eto_d = 1'b1;
            pst_d = P_SYNC;
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            pst_q       <= P_SYNC;
            cmd_q       <= 8'h00;
            arg0_q      <= 8'h00;
            arg1_q      <= 8'h00;
            cfg_q       <= '0;
            cfg_valid_q <= 1'b0;
            cap_q       <= 1'b0;
            res_q       <= 1'b0;
            echk_q      <= 1'b0;
            ecmd_q      <= 1'b0;
            eovr_q      <= 1'b0;
            eto_q       <= 1'b0;
        end else begin
            pst_q       <= pst_d;
            cmd_q       <= cmd_d;
            arg0_q      <= arg0_d;
            arg1_q      <= arg1_d;
            cfg_q       <= cfg_d;
            cfg_valid_q <= cfg_valid_d;
            cap_q       <= cap_d;
            res_q       <= res_d;
            echk_q      <= echk_d;
            ecmd_q      <= ecmd_d;
            eovr_q      <= eovr_d;
            eto_q       <= eto_d;
        end
    end

    assign cmd.rx_byte_valid = byte_vld;
    assign cmd.rx_byte       = rx_byte;
    assign cmd.capture_pulse = cap_q;
    assign cmd.resend_pulse  = res_q;
    assign cmd.cfg_valid     = cfg_valid_q;
    assign cmd.cfg_addr      = cfg_q.addr;
    assign cmd.cfg_data      = cfg_q.data;
    assign cmd.err_frame     = ferr;
    assign cmd.err_chk       = echk_q;
    assign cmd.err_cmd       = ecmd_q;
    assign cmd.err_ovr       = eovr_q;
    assign cmd.err_timeout   = eto_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: serial packet table with an event scoreboard, plus corner sequences.
// Define CMD_TIMEOUT_EN on both RTL and bench to exercise the packet timeout.
module tb_uart_cmd_rx;
    import cam_link_pkg::*;

    localparam int CPB = 16;
    localparam int TO  = 1000;

    localparam logic [3:0] EV_BYTE = 4'd0;
    localparam logic [3:0] EV_CAP  = 4'd1;
    localparam logic [3:0] EV_RES  = 4'd2;
    localparam logic [3:0] EV_CFG  = 4'd3;
    localparam logic [3:0] EV_EFRM = 4'd4;
    localparam logic [3:0] EV_ECHK = 4'd5;
    localparam logic [3:0] EV_ECMD = 4'd6;
    localparam logic [3:0] EV_EOVR = 4'd7;
    localparam logic [3:0] EV_ETO  = 4'd8;

    typedef struct packed {
        logic [3:0]  kind;
        logic [15:0] val;
    } ev_t;

    typedef struct packed {
        logic [39:0] pkt;
        logic [3:0]  ev;
    } vec_t;

    logic clk = 1'b0;
    logic reset_p;
    logic rx_serial;
    always #5 clk = ~clk;

    uart_cmd_rx_if bus ();

    uart_cmd_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
        .clk      (clk),
        .reset_p  (reset_p),
        .rx_serial(rx_serial),
        .cmd      (bus)
    );

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  seen  = 0;
    int  cyc   = 0;
    logic cfg_prev = 1'b0;
`ifdef CMD_TIMEOUT_EN
    int last_byte_cyc = 0;
    int to_gap = -1;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic observe(input logic [3:0] k, input logic [15:0] v);
        ev_t e;
        seen++;
        tests++;
`ifdef CMD_TIMEOUT_EN
        if (k == EV_BYTE) last_byte_cyc = cyc;
        if (k == EV_ETO)  to_gap = cyc - last_byte_cyc;
`endif
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected: got kind %0d val %h, expected no event", k, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== k || e.val !== v) begin
                fails++;
                $display("FAIL sb_event: got kind %0d val %h, expected kind %0d val %h",
                         k, v, e.kind, e.val);
            end
        end
    endtask

    // Output monitor: every pulse (and every cfg_valid rising edge) is one scoreboard event
    always @(negedge clk) begin
        if (reset_p) begin
            cfg_prev = 1'b0;
        end else begin
            if (bus.rx_byte_valid) observe(EV_BYTE, {8'h00, bus.rx_byte});
            if (bus.capture_pulse) observe(EV_CAP, 16'h0);
            if (bus.resend_pulse)  observe(EV_RES, 16'h0);
            if (bus.cfg_valid && !cfg_prev) observe(EV_CFG, {bus.cfg_addr, bus.cfg_data});
            if (bus.err_frame)     observe(EV_EFRM, 16'h0);
            if (bus.err_chk)       observe(EV_ECHK, 16'h0);
            if (bus.err_cmd)       observe(EV_ECMD, 16'h0);
            if (bus.err_ovr)       observe(EV_EOVR, 16'h0);
            if (bus.err_timeout)   observe(EV_ETO, 16'h0);
            cfg_prev = bus.cfg_valid;
        end
    end

    task automatic push(input logic [3:0] k, input logic [15:0] v);
        exp_q.push_back('{kind: k, val: v});
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk) rx_serial = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_serial = stop;
        repeat (CPB) @(negedge clk);
        rx_serial = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_pkt(input logic [39:0] p, input logic [3:0] fin);
        logic [7:0] b;
        for (int i = 0; i < 5; i++) begin
            b = p[39-8*i -: 8];
            push(EV_BYTE, {8'h00, b});
        end
        push(fin, (fin == EV_CFG) ? p[23:8] : 16'h0);
        for (int i = 0; i < 5; i++) begin
            b = p[39-8*i -: 8];
            send_byte(b, 1'b1);
        end
    endtask

    task automatic drain(input string name);
        repeat (3 * CPB) @(negedge clk);
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic cfg_handshake(input logic [15:0] exp_ad, input int hold);
        logic bad;
        bad = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            if (!(bus.cfg_valid === 1'b1 && {bus.cfg_addr, bus.cfg_data} === exp_ad)) bad = 1'b1;
        end
        check("cfg_hold", 32'(bad), 32'd0);
        bus.cfg_ready = 1'b1;
        @(negedge clk);
        bus.cfg_ready = 1'b0;
        check("cfg_clear", 32'(bus.cfg_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", tests);
        $fatal(1);
    end

    initial begin
        vec_t vt[9];
        int   s;
        vt[0] = '{pkt: 40'hA5_01_00_00_01, ev: EV_CAP};
        vt[1] = '{pkt: 40'hA5_01_00_00_00, ev: EV_ECHK};
        vt[2] = '{pkt: 40'hA5_03_00_00_03, ev: EV_RES};
        vt[3] = '{pkt: 40'hA5_07_11_22_34, ev: EV_ECMD};
        vt[4] = '{pkt: 40'hA5_02_12_80_90, ev: EV_CFG};
        vt[5] = '{pkt: 40'hA5_02_A5_01_A6, ev: EV_CFG};
        vt[6] = '{pkt: 40'hA5_03_A5_A5_03, ev: EV_RES};
        vt[7] = '{pkt: 40'hA5_00_00_00_00, ev: EV_ECMD};
        vt[8] = '{pkt: 40'hA5_04_00_00_04, ev: EV_ECMD};

        reset_p       = 1'b1;
        rx_serial     = 1'b1;
        bus.cfg_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_byte", 32'({bus.rx_byte_valid, bus.rx_byte}), 32'd0);
        check("rst_ctl", 32'({bus.capture_pulse, bus.resend_pulse, bus.cfg_valid, bus.cfg_addr,
                              bus.cfg_data, bus.err_frame, bus.err_chk, bus.err_cmd,
                              bus.err_ovr, bus.err_timeout}), 32'd0);
        reset_p = 1'b0;
        repeat (CPB) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            send_pkt(vt[i].pkt, vt[i].ev);
            if (vt[i].ev == EV_CFG) cfg_handshake(vt[i].pkt[23:8], 50);
            drain($sformatf("vec%0d_drain", i));
        end

        // Framing error, then a good byte and junk outside any packet
        push(EV_EFRM, 16'h0);
        send_byte(8'h55, 1'b0);
        push(EV_BYTE, 16'h003C);
        push(EV_BYTE, 16'h005A);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h5A, 1'b1);
        drain("frame_drain");

        // Short glitch on the idle line
        s = seen;
        @(negedge clk) rx_serial = 1'b0;
        repeat (8) @(negedge clk);
        rx_serial = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        check("glitch_quiet", 32'(seen - s), 32'd0);

        // Byte arriving while a register write is pending
        send_pkt(40'hA5_02_34_56_60, EV_CFG);
        push(EV_BYTE, 16'h0077);
        push(EV_EOVR, 16'h0);
        send_byte(8'h77, 1'b1);
        cfg_handshake(16'h3456, 4);
        drain("ovr_drain");
        send_pkt(40'hA5_01_00_00_01, EV_CAP);
        drain("ovr_recover");

        // Reset mid-packet discards the partial packet
        push(EV_BYTE, 16'h00A5);
        push(EV_BYTE, 16'h0002);
        push(EV_BYTE, 16'h0012);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        reset_p = 1'b1;
        repeat (2) @(negedge clk);
        reset_p = 1'b0;
        push(EV_BYTE, 16'h0080);
        push(EV_BYTE, 16'h0090);
        send_byte(8'h80, 1'b1);
        send_byte(8'h90, 1'b1);
        drain("rst_pkt_drain");

        // Reset drops a pending register write
        send_pkt(40'hA5_02_12_80_90, EV_CFG);
        reset_p = 1'b1;
        repeat (2) @(negedge clk);
        reset_p = 1'b0;
        @(negedge clk);
        check("rst_cfg_drop", 32'(bus.cfg_valid), 32'd0);
        drain("rst_cfg_drain");
        send_pkt(40'hA5_03_00_00_03, EV_RES);
        drain("rst_recover");

`ifdef CMD_TIMEOUT_EN
        push(EV_BYTE, 16'h00A5);
        push(EV_BYTE, 16'h0001);
        push(EV_ETO, 16'h0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        repeat (TO + 50) @(negedge clk);
        check("to_latency_ok", 32'((to_gap >= TO) && (to_gap <= TO + 2)), 32'd1);
        drain("to_drain");
        send_pkt(40'hA5_01_00_00_01, EV_CAP);
        drain("to_recover");
`else
        // Without the timeout a partial packet simply waits
        push(EV_BYTE, 16'h00A5);
        push(EV_BYTE, 16'h0001);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        repeat (TO + 500) @(negedge clk);
        drain("wait_partial");
        push(EV_BYTE, 16'h0000);
        push(EV_BYTE, 16'h0000);
        push(EV_BYTE, 16'h0001);
        push(EV_CAP, 16'h0);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        drain("wait_complete");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
